// File: rtl/writeback_commit_unit_l4_if.sv
// Writeback/commit bundle: execute-pipe results in, completion notify out,
// squash request in, and the in-order commit port out.
interface writeback_commit_unit_l4_if #(
    parameter int p_num_pipes      = 2,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
);
    // Handshakes: pipe i transfers when ex_val[i] & ex_rdy[i] at a rising edge;
    // a commit retires when commit_val & commit_rdy at a rising edge. A producer
    // holds valid and payload stable until the transfer; ready never waits on valid
    // being withdrawn, and commit_* stays stable while commit_rdy is low.
    logic [p_num_pipes-1:0]                        ex_val;
    logic [p_num_pipes-1:0]                        ex_rdy;
    logic [p_num_pipes-1:0][31:0]                  ex_pc;
    logic [p_num_pipes-1:0][p_seq_num_bits-1:0]    ex_seq_num;
    logic [p_num_pipes-1:0][4:0]                   ex_waddr;
    logic [p_num_pipes-1:0][31:0]                  ex_wdata;
    logic [p_num_pipes-1:0]                        ex_wen;
    logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]  ex_preg;
    logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]  ex_ppreg;

    logic                        complete_val;
    logic [p_seq_num_bits-1:0]   complete_seq_num;
    logic [4:0]                  complete_waddr;
    logic [31:0]                 complete_wdata;
    logic                        complete_wen;
    logic [p_phys_addr_bits-1:0] complete_preg;

    logic                        squash_val;
    logic [p_seq_num_bits-1:0]   squash_seq_num;

    logic                        commit_val;
    logic                        commit_rdy;
    logic [p_seq_num_bits-1:0]   commit_seq_num;
    logic [31:0]                 commit_pc;
    logic [4:0]                  commit_waddr;
    logic [31:0]                 commit_wdata;
    logic                        commit_wen;
    logic [p_phys_addr_bits-1:0] commit_ppreg;

    modport master (
        output ex_val, ex_pc, ex_seq_num, ex_waddr, ex_wdata, ex_wen, ex_preg, ex_ppreg,
        input  ex_rdy,
        input  complete_val, complete_seq_num, complete_waddr, complete_wdata,
               complete_wen, complete_preg,
        output squash_val, squash_seq_num,
        input  commit_val, commit_seq_num, commit_pc, commit_waddr, commit_wdata,
               commit_wen, commit_ppreg,
        output commit_rdy
    );

    modport slave (
        input  ex_val, ex_pc, ex_seq_num, ex_waddr, ex_wdata, ex_wen, ex_preg, ex_ppreg,
        output ex_rdy,
        output complete_val, complete_seq_num, complete_waddr, complete_wdata,
               complete_wen, complete_preg,
        input  squash_val, squash_seq_num,
        output commit_val, commit_seq_num, commit_pc, commit_waddr, commit_wdata,
               commit_wen, commit_ppreg,
        input  commit_rdy
    );
endinterface

// File: rtl/writeback_commit_unit_l4.sv
// Writeback/commit unit: age-ordered grant across N execute pipes, one X stage,
// a 2^S-entry ROB indexed by sequence number, in-order commit with squash.
module writeback_commit_unit_l4 #(
    parameter int p_num_pipes      = 2,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    writeback_commit_unit_l4_if.slave       io_wb
);
    localparam int D  = 2 ** p_seq_num_bits;
    localparam int IW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    typedef logic [p_seq_num_bits-1:0]   seq_t;
    typedef logic [p_phys_addr_bits-1:0] preg_t;

    seq_t            r_head;
    logic [D-1:0]    r_rob_val;
    logic [31:0]     r_rob_pc    [D];
    logic [4:0]      r_rob_waddr [D];
    logic [31:0]     r_rob_wdata [D];
    logic            r_rob_wen   [D];
    preg_t           r_rob_ppreg [D];

    logic            r_x_val;
    seq_t            r_x_seq;
    logic [31:0]     r_x_pc;
    logic [4:0]      r_x_waddr;
    logic [31:0]     r_x_wdata;
    logic            r_x_wen;
    preg_t           r_x_ppreg;

    seq_t            w_ex_age   [p_num_pipes];
    seq_t            w_slot_age [D];
    seq_t            w_sq_age;
    seq_t            w_x_age;
    logic            w_gnt_any;
    logic [IW-1:0]   w_gnt_idx;
    seq_t            w_gnt_age;
    logic            w_gnt_kill;
    logic            w_cmp_val;
    logic            w_cmp_wen;
    logic [p_num_pipes-1:0] w_rdy;
    logic            w_ins;
    logic            w_commit_fire;
    logic [D-1:0]    w_rob_val_nxt;

    // Ages are distances from the current head, so wrap-around needs no special case.
    always_comb begin
        for (int i = 0; i < p_num_pipes; i++) begin
            w_ex_age[i] = io_wb.ex_seq_num[i] - r_head;
        end
        for (int j = 0; j < D; j++) begin
            w_slot_age[j] = seq_t'(j) - r_head;
        end
    end

    assign w_sq_age = io_wb.squash_seq_num - r_head;
    assign w_x_age  = r_x_seq - r_head;

    // Strict '<' keeps the lowest pipe index on an age tie.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_age = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            if (io_wb.ex_val[i] && (!w_gnt_any || (w_ex_age[i] < w_gnt_age))) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IW'(i);
                w_gnt_age = w_ex_age[i];
            end
        end
    end

    always_comb begin
        w_rdy = '0;
        if (w_gnt_any) begin
            w_rdy[w_gnt_idx] = 1'b1;
        end
    end

    // A squashed grant still drains the pipe but never reaches completion or the X stage.
    assign w_gnt_kill = io_wb.squash_val && (w_gnt_age > w_sq_age);
    assign w_cmp_val  = w_gnt_any && !w_gnt_kill;
    assign w_cmp_wen  = io_wb.ex_wen[w_gnt_idx] && (io_wb.ex_waddr[w_gnt_idx] != 5'd0);

    assign io_wb.ex_rdy           = w_rdy;
    assign io_wb.complete_val     = w_cmp_val;
    assign io_wb.complete_seq_num = io_wb.ex_seq_num[w_gnt_idx];
    assign io_wb.complete_waddr   = io_wb.ex_waddr[w_gnt_idx];
    assign io_wb.complete_wdata   = io_wb.ex_wdata[w_gnt_idx];
    assign io_wb.complete_wen     = w_cmp_wen;
    assign io_wb.complete_preg    = io_wb.ex_preg[w_gnt_idx];

    assign w_ins         = r_x_val && !(io_wb.squash_val && (w_x_age > w_sq_age));
    assign w_commit_fire = r_rob_val[r_head] && io_wb.commit_rdy;

    always_comb begin
        w_rob_val_nxt = r_rob_val;
        for (int j = 0; j < D; j++) begin
            if (io_wb.squash_val && (w_slot_age[j] > w_sq_age)) begin
                w_rob_val_nxt[j] = 1'b0;
            end
        end
        if (w_commit_fire) begin
            w_rob_val_nxt[r_head] = 1'b0;
        end
        if (w_ins) begin
            w_rob_val_nxt[r_x_seq] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_rob_val <= '0;
            r_x_val   <= 1'b0;
        end else begin
            r_head    <= r_head + seq_t'(w_commit_fire);
            r_rob_val <= w_rob_val_nxt;
            r_x_val   <= w_cmp_val;
        end
    end

    // Payload storage needs no reset; the valid bits above qualify it.
    always_ff @(posedge clk) begin
        if (w_cmp_val) begin
            r_x_seq   <= io_wb.ex_seq_num[w_gnt_idx];
            r_x_pc    <= io_wb.ex_pc[w_gnt_idx];
            r_x_waddr <= io_wb.ex_waddr[w_gnt_idx];
            r_x_wdata <= io_wb.ex_wdata[w_gnt_idx];
            r_x_wen   <= w_cmp_wen;
            r_x_ppreg <= io_wb.ex_ppreg[w_gnt_idx];
        end
        if (w_ins) begin
            r_rob_pc[r_x_seq]    <= r_x_pc;
            r_rob_waddr[r_x_seq] <= r_x_waddr;
            r_rob_wdata[r_x_seq] <= r_x_wdata;
            r_rob_wen[r_x_seq]   <= r_x_wen;
            r_rob_ppreg[r_x_seq] <= r_x_ppreg;
        end
    end

    assign io_wb.commit_val     = r_rob_val[r_head];
    assign io_wb.commit_seq_num = r_head;
    assign io_wb.commit_pc      = r_rob_pc[r_head];
    assign io_wb.commit_waddr   = r_rob_waddr[r_head];
    assign io_wb.commit_wdata   = r_rob_wdata[r_head];
    assign io_wb.commit_wen     = r_rob_wen[r_head];
    assign io_wb.commit_ppreg   = r_rob_ppreg[r_head];

    // Protocol checks: double insert, and a grant that cannot fit a full ROB.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_ins) begin
                assert (!r_rob_val[r_x_seq]);
            end
            if (w_gnt_any) begin
                assert (!((&r_rob_val) && (w_gnt_age == seq_t'(D - 1))));
            end
        end
    end
endmodule

// File: tb/tb_writeback_commit_unit_l4.sv
// Directed bench: ROB-level model checked every cycle, plus literal spot checks.
module tb_writeback_commit_unit_l4;
    localparam int N = 2;
    localparam int S = 5;
    localparam int P = 6;
    localparam int D = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_commit_unit_l4_if #(.p_num_pipes(N), .p_seq_num_bits(S), .p_phys_addr_bits(P)) bus();

    writeback_commit_unit_l4 #(.p_num_pipes(N), .p_seq_num_bits(S), .p_phys_addr_bits(P)) dut (
        .clk   (clk),
        .rst   (rst),
        .io_wb (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [S-1:0] commit_log[$];
    logic [S-1:0] exp_q[$];

    typedef struct {
        bit           v;
        logic [31:0]  pc;
        logic [4:0]   waddr;
        logic [31:0]  wdata;
        bit           wen;
        logic [P-1:0] ppreg;
    } ent_t;

    ent_t m_rob [D];
    ent_t m_x;
    int   m_x_seq;
    int   m_head;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int age_of(input int s, input int h);
        return (s - h + D) % D;
    endfunction

    // Model: ROB as an array of entries keyed by sequence number, head as an int.
    always @(negedge clk) begin : model_cmp
        int  g;
        int  best;
        int  a;
        int  a_sq;
        bit  kill;
        bit  cval;
        bit  fire;
        if (rst) begin
            m_head = 0;
            m_x.v  = 1'b0;
            for (int j = 0; j < D; j++) m_rob[j].v = 1'b0;
        end else begin
            g    = -1;
            best = D;
            for (int i = 0; i < N; i++) begin
                if (bus.ex_val[i]) begin
                    a = age_of(int'(bus.ex_seq_num[i]), m_head);
                    if (a < best) begin
                        best = a;
                        g    = i;
                    end
                end
            end
            a_sq = age_of(int'(bus.squash_seq_num), m_head);
            kill = (g >= 0) && bus.squash_val && (best > a_sq);
            cval = (g >= 0) && !kill;

            check("ex_rdy", 64'(bus.ex_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
            check("complete_val", 64'(bus.complete_val), 64'(cval));
            if (cval) begin
                check("complete_seq_num", 64'(bus.complete_seq_num), 64'(bus.ex_seq_num[g]));
                check("complete_waddr", 64'(bus.complete_waddr), 64'(bus.ex_waddr[g]));
                check("complete_wdata", 64'(bus.complete_wdata), 64'(bus.ex_wdata[g]));
                check("complete_wen", 64'(bus.complete_wen),
                      64'(bus.ex_wen[g] && (bus.ex_waddr[g] != 5'd0)));
                check("complete_preg", 64'(bus.complete_preg), 64'(bus.ex_preg[g]));
            end

            check("commit_val", 64'(bus.commit_val), 64'(m_rob[m_head].v));
            check("commit_seq_num", 64'(bus.commit_seq_num), 64'(m_head));
            if (m_rob[m_head].v) begin
                check("commit_pc", 64'(bus.commit_pc), 64'(m_rob[m_head].pc));
                check("commit_waddr", 64'(bus.commit_waddr), 64'(m_rob[m_head].waddr));
                check("commit_wdata", 64'(bus.commit_wdata), 64'(m_rob[m_head].wdata));
                check("commit_wen", 64'(bus.commit_wen), 64'(m_rob[m_head].wen));
                check("commit_ppreg", 64'(bus.commit_ppreg), 64'(m_rob[m_head].ppreg));
            end
            if (bus.commit_val && bus.commit_rdy) commit_log.push_back(bus.commit_seq_num);

            // Advance one clock; all ages use the head from before this edge.
            fire = m_rob[m_head].v && bus.commit_rdy;
            if (bus.squash_val) begin
                for (int j = 0; j < D; j++) begin
                    if (age_of(j, m_head) > a_sq) m_rob[j].v = 1'b0;
                end
            end
            if (fire) m_rob[m_head].v = 1'b0;
            if (m_x.v && !(bus.squash_val && (age_of(m_x_seq, m_head) > a_sq))) begin
                m_rob[m_x_seq]   = m_x;
                m_rob[m_x_seq].v = 1'b1;
            end
            if (cval) begin
                m_x.v     = 1'b1;
                m_x.pc    = bus.ex_pc[g];
                m_x.waddr = bus.ex_waddr[g];
                m_x.wdata = bus.ex_wdata[g];
                m_x.wen   = bus.ex_wen[g] && (bus.ex_waddr[g] != 5'd0);
                m_x.ppreg = bus.ex_ppreg[g];
                m_x_seq   = int'(bus.ex_seq_num[g]);
            end else begin
                m_x.v = 1'b0;
            end
            m_head = (m_head + (fire ? 1 : 0)) % D;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_val     = '0;
        bus.squash_val = 1'b0;
    endtask

    task automatic drive(input int p, input int seq, input int waddr,
                         input logic [31:0] wdata, input bit wen);
        bus.ex_val[p]     = 1'b1;
        bus.ex_seq_num[p] = seq[S-1:0];
        bus.ex_waddr[p]   = waddr[4:0];
        bus.ex_wdata[p]   = wdata;
        bus.ex_wen[p]     = wen;
        bus.ex_pc[p]      = 32'(32'h1000 + seq * 4);
        bus.ex_preg[p]    = P'(seq + 8);
        bus.ex_ppreg[p]   = P'(seq + 40);
    endtask

    task automatic send(input int p, input int seq);
        drive(p, seq, (seq % 31) + 1, 32'hA000_0000 | 32'(seq), 1'b1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 64'(commit_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < commit_log.size(); i++) begin
            check(name, 64'(commit_log[i]), 64'(exp_q[i]));
        end
        commit_log.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        rst                = 1'b1;
        bus.ex_val         = '0;
        bus.ex_pc          = '0;
        bus.ex_seq_num     = '0;
        bus.ex_waddr       = '0;
        bus.ex_wdata       = '0;
        bus.ex_wen         = '0;
        bus.ex_preg        = '0;
        bus.ex_ppreg       = '0;
        bus.squash_val     = 1'b0;
        bus.squash_seq_num = '0;
        bus.commit_rdy     = 1'b0;
        reset_dut();

        // Reset state
        #1;
        check("rst_commit_val", 64'(bus.commit_val), 64'd0);
        check("rst_complete_val", 64'(bus.complete_val), 64'd0);
        check("rst_ex_rdy", 64'(bus.ex_rdy), 64'd0);
        check("rst_head", 64'(bus.commit_seq_num), 64'd0);

        // Single pipe, seq 0, waddr 3, wdata 0xDEAD
        bus.commit_rdy = 1'b1;
        drive(0, 0, 3, 32'hDEAD, 1'b1);
        #1;
        check("t1_complete_val", 64'(bus.complete_val), 64'd1);
        check("t1_complete_wen", 64'(bus.complete_wen), 64'd1);
        check("t1_complete_wdata", 64'(bus.complete_wdata), 64'hDEAD);
        check("t1_ex_rdy", 64'(bus.ex_rdy), 64'b01);
        tick(); idle(); #1;
        check("t1_commit_val_t1", 64'(bus.commit_val), 64'd0);
        tick(); #1;
        check("t1_commit_val_t2", 64'(bus.commit_val), 64'd1);
        check("t1_commit_seq", 64'(bus.commit_seq_num), 64'd0);
        check("t1_commit_wen", 64'(bus.commit_wen), 64'd1);
        check("t1_commit_waddr", 64'(bus.commit_waddr), 64'd3);
        check("t1_commit_wdata", 64'(bus.commit_wdata), 64'hDEAD);
        tick(); #1;
        check("t1_head_after", 64'(bus.commit_seq_num), 64'd1);
        check("t1_commit_val_after", 64'(bus.commit_val), 64'd0);

        // Out-of-order completion, in-order commit
        reset_dut();
        commit_log.delete();
        bus.commit_rdy = 1'b1;
        send(1, 1);
        tick(); idle(); send(0, 0); #1;
        check("t2_ex_rdy", 64'(bus.ex_rdy), 64'b01);
        tick(); idle(); #1;
        check("t2_commit_val_wait", 64'(bus.commit_val), 64'd0);
        tick(); #1;
        check("t2_first_seq", 64'(bus.commit_seq_num), 64'd0);
        check("t2_first_val", 64'(bus.commit_val), 64'd1);
        tick(); #1;
        check("t2_second_seq", 64'(bus.commit_seq_num), 64'd1);
        check("t2_second_val", 64'(bus.commit_val), 64'd1);
        tick(); tick();
        exp_q.push_back(5'd0); exp_q.push_back(5'd1);
        check_log("t2_log");

        // Age arbitration across the wrap: advance head to 30
        reset_dut();
        bus.commit_rdy = 1'b1;
        for (int s = 0; s < 30; s++) begin
            idle(); send(0, s); tick();
        end
        idle();
        repeat (3) tick();
        #1;
        check("t3_head30", 64'(bus.commit_seq_num), 64'd30);
        commit_log.delete();
        send(0, 1); send(1, 31); #1;
        check("t3_gnt_seq31", 64'(bus.ex_rdy), 64'b10);
        check("t3_cmp_seq31", 64'(bus.complete_seq_num), 64'd31);
        tick(); idle(); send(0, 1); #1;
        check("t3_gnt_seq1", 64'(bus.ex_rdy), 64'b01);
        tick(); idle(); send(0, 30); send(1, 0); #1;
        check("t3_gnt_seq30", 64'(bus.ex_rdy), 64'b01);
        tick(); idle(); send(1, 0);
        tick(); idle();
        repeat (6) tick();
        exp_q.push_back(5'd30); exp_q.push_back(5'd31);
        exp_q.push_back(5'd0);  exp_q.push_back(5'd1);
        check_log("t3_log");

        // Commit backpressure
        reset_dut();
        bus.commit_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            idle(); send(0, s); tick();
        end
        idle();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_stall_val", 64'(bus.commit_val), 64'd1);
            check("t4_stall_seq", 64'(bus.commit_seq_num), 64'd0);
            tick();
        end
        bus.commit_rdy = 1'b1;
        #1; check("t4_rel_seq0", 64'(bus.commit_seq_num), 64'd0);
        tick(); #1; check("t4_rel_seq1", 64'(bus.commit_seq_num), 64'd1);
        check("t4_rel_val1", 64'(bus.commit_val), 64'd1);
        tick(); #1; check("t4_rel_seq2", 64'(bus.commit_seq_num), 64'd2);
        check("t4_rel_val2", 64'(bus.commit_val), 64'd1);
        tick(); #1; check("t4_rel_done", 64'(bus.commit_val), 64'd0);
        commit_log.delete();

        // Squash seq 2 with 1,3,4 in the ROB and 5 in the X stage
        reset_dut();
        bus.commit_rdy = 1'b1;
        send(0, 0);
        tick(); idle(); tick(); tick();
        bus.commit_rdy = 1'b0;
        commit_log.delete();
        send(0, 1); tick(); idle();
        send(0, 3); tick(); idle();
        send(0, 4); tick(); idle();
        send(0, 5); tick(); idle();
        bus.squash_val     = 1'b1;
        bus.squash_seq_num = 5'd2;
        send(0, 6); #1;
        check("t5_drain_rdy", 64'(bus.ex_rdy), 64'b01);
        check("t5_drain_cmp", 64'(bus.complete_val), 64'd0);
        check("t5_head1_val", 64'(bus.commit_val), 64'd1);
        tick(); idle();
        bus.commit_rdy = 1'b1; #1;
        check("t5_commit1", 64'(bus.commit_seq_num), 64'd1);
        tick(); #1;
        check("t5_wait2_val", 64'(bus.commit_val), 64'd0);
        check("t5_wait2_seq", 64'(bus.commit_seq_num), 64'd2);
        send(0, 2); tick(); idle(); tick(); #1;
        check("t5_commit2_val", 64'(bus.commit_val), 64'd1);
        check("t5_commit2_seq", 64'(bus.commit_seq_num), 64'd2);
        repeat (6) tick();
        #1;
        check("t5_no_more_val", 64'(bus.commit_val), 64'd0);
        check("t5_no_more_seq", 64'(bus.commit_seq_num), 64'd3);
        exp_q.push_back(5'd1); exp_q.push_back(5'd2);
        check_log("t5_log");

        // waddr 0 with wen 1 never writes
        drive(0, 3, 0, 32'h5555, 1'b1); #1;
        check("t6_complete_val", 64'(bus.complete_val), 64'd1);
        check("t6_complete_wen", 64'(bus.complete_wen), 64'd0);
        tick(); idle(); tick(); #1;
        check("t6_commit_val", 64'(bus.commit_val), 64'd1);
        check("t6_commit_wen", 64'(bus.commit_wen), 64'd0);
        check("t6_commit_wdata", 64'(bus.commit_wdata), 64'h5555);
        tick();

        // Mid-stream reset
        bus.commit_rdy = 1'b0;
        send(0, 4); tick(); idle();
        send(0, 5); tick(); idle();
        #1;
        check("t7_pre_val", 64'(bus.commit_val), 64'd1);
        check("t7_pre_seq", 64'(bus.commit_seq_num), 64'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t7_post_val", 64'(bus.commit_val), 64'd0);
        check("t7_post_head", 64'(bus.commit_seq_num), 64'd0);
        check("t7_post_rdy", 64'(bus.ex_rdy), 64'd0);
        bus.commit_rdy = 1'b1;
        repeat (4) tick();
        #1;
        check("t7_quiet_val", 64'(bus.commit_val), 64'd0);
        commit_log.delete();
        check_log("t7_log");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
